redundant_normalizer: RTL and testbench

- Back-end consumer of the post-adder output: takes one redundant_poly_L3 word (ADD_DIV limbs, each a val plus a signed carry) and returns the canonical Fp integer in [0, p).
- Stage 1 resolves carries limb-serially; stage 2 applies iterative conditional ±p correction; result is handed off on a valid/ready interface.
- Sits between postadder dout and any block needing non-redundant Fp values (final output, comparison, memory writeback).

---
 rtl/PARAMS_BN254_d0.sv | 37 +++
 rtl/redundant_normalizer_resolver.sv | 22 ++
 rtl/redundant_normalizer.sv | 118 +++++++++++
 tb/tb_redundant_normalizer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/PARAMS_BN254_d0.sv
// BN254 base-field parameters and the redundant-word types shared by the
// post-adder back end and the redundant_normalizer.
package PARAMS_BN254_d0;

  localparam int ADD_DIV = 4;
  localparam int W_LIMB  = 64;
  localparam int W_CARRY = 8;
  localparam int MAX_RED = 8;
  localparam int W_FP    = ADD_DIV * W_LIMB;
  localparam int W_CIN   = W_CARRY + 2;
  localparam int W_WIDE  = W_FP + W_CARRY + 2;

  typedef logic [W_LIMB-1:0] fp_div4_t;
  typedef logic [W_FP-1:0]   uint_fp_t;

  // One limb: val plus a two's-complement carry weighted by 2^W_LIMB.
  typedef struct packed {
    logic signed [W_CARRY-1:0] carry;
    fp_div4_t                  val;
  } red_limb_t;

  typedef red_limb_t [ADD_DIV-1:0] redundant_poly_L3;

  typedef logic signed [W_WIDE-1:0] rn_wide_t;
  typedef logic signed [W_CIN-1:0]  rn_cin_t;

  localparam uint_fp_t Mod =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef enum logic [1:0] {
    RN_IDLE,
    RN_RESOLVE,
    RN_REDUCE,
    RN_OUT
  } rn_state_e;

endpackage

// File: rtl/redundant_normalizer_resolver.sv
// Combinational single-limb carry-resolve step: folds the incoming carry into
// val, emits the canonical limb and the signed carry for the next limb.
module rn_limb_resolver
  import PARAMS_BN254_d0::*;
(
  input  fp_div4_t                  val,
  input  logic signed [W_CARRY-1:0] carry,
  input  rn_cin_t                   cin,
  output fp_div4_t                  limb,
  output rn_cin_t                   cout
);

  localparam int W_S = W_LIMB + W_CARRY + 2;

  logic [W_S-1:0] s;

  assign s = {{(W_S-W_LIMB){1'b0}}, val} + {{(W_S-W_CIN){cin[W_CIN-1]}}, cin};
  assign limb = s[W_LIMB-1:0];
  // Upper slice of s is exactly s >>> W_LIMB in W_CIN bits.
  assign cout = s[W_S-1:W_LIMB] + {{(W_CIN-W_CARRY){carry[W_CARRY-1]}}, carry};

endmodule

// File: rtl/redundant_normalizer.sv
// Converts one redundant_poly_L3 word to the canonical Fp integer in [0, p):
// limb-serial carry resolve, then bounded iterative +/-p correction.
module redundant_normalizer
  import PARAMS_BN254_d0::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  redundant_poly_L3 din,
  output logic             out_valid,
  input  logic             out_ready,
  output uint_fp_t         dout,
  output logic             err
);

  // Handshake: a word moves on any edge where valid and ready are both high;
  // in_ready is only high in IDLE and out_valid only in OUT, so the block
  // holds at most one word and input/output never overlap.

  localparam int       IDX_W  = $clog2(ADD_DIV) + 1;
  localparam int       CNT_W  = $clog2(MAX_RED + 1);
  localparam rn_wide_t P_WIDE = rn_wide_t'({{(W_WIDE-W_FP){1'b0}}, Mod});

  rn_state_e                state;
  redundant_poly_L3         din_q;
  logic [IDX_W-1:0]         idx;
  rn_cin_t                  cin_q;
  fp_div4_t [ADD_DIV-1:0]   limbs_q;
  rn_wide_t                 v_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [IDX_W-2:0]         sel;
  red_limb_t                cur;
  fp_div4_t                 limb_nxt;
  rn_cin_t                  cout_nxt;
  logic                     v_neg;
  logic                     v_big;

  assign sel   = idx[IDX_W-2:0];
  assign cur   = din_q[sel];
  assign v_neg = v_q[W_WIDE-1];
  assign v_big = !v_neg && (v_q >= P_WIDE);

  rn_limb_resolver u_resolver (
    .val   (cur.val),
    .carry (cur.carry),
    .cin   (cin_q),
    .limb  (limb_nxt),
    .cout  (cout_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RN_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      err       <= 1'b0;
      din_q     <= '0;
      idx       <= '0;
      cin_q     <= '0;
      limbs_q   <= '0;
      v_q       <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        RN_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            din_q    <= din;
            idx      <= '0;
            cin_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state    <= RN_RESOLVE;
          end
        end
        RN_RESOLVE: begin
          // Extra cycle after the last limb assembles the wide value.
          if (idx == IDX_W'(ADD_DIV)) begin
            v_q   <= {cin_q, limbs_q};
            state <= RN_REDUCE;
          end else begin
            limbs_q[sel] <= limb_nxt;
            cin_q        <= cout_nxt;
            idx          <= idx + 1'b1;
          end
        end
        RN_REDUCE: begin
          if (!v_neg && !v_big) begin
            dout      <= v_q[W_FP-1:0];
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= RN_OUT;
          end else if (cnt_q == CNT_W'(MAX_RED)) begin
            dout      <= v_q[W_FP-1:0];
            err       <= 1'b1;
            out_valid <= 1'b1;
            state     <= RN_OUT;
          end else begin
            v_q   <= v_neg ? (v_q + P_WIDE) : (v_q - P_WIDE);
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RN_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= RN_IDLE;
          end
        end
        default: state <= RN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redundant_normalizer.sv
// Randomized scoreboard bench for redundant_normalizer with an arithmetic
// reference model (exact integer value, division-based correction count).
module tb_redundant_normalizer;
  import PARAMS_BN254_d0::*;

  localparam int EXP_W = 1 + 8 + W_FP;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  redundant_poly_L3 din = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  uint_fp_t         dout;
  logic             err;

  int n_cmp = 0;
  int n_fail = 0;
  int cycle = 0;
  int bp_mode = 0;
  int hold_cnt = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               acc_q[$];

  redundant_normalizer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W_FP-1:0] act,
                       input logic [W_FP-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Exact value of the word, then the number of +/-p steps needed to land in
  // [0, p), capped at MAX_RED with err set.
  function automatic logic [EXP_W-1:0] model(input redundant_poly_L3 d);
    logic [299:0] total, term, pw, mag, q, res;
    logic         neg, e;
    int           k;
    total = '0;
    for (int i = 0; i < ADD_DIV; i++) begin
      term  = {236'd0, d[i].val} + ({{292{d[i].carry[W_CARRY-1]}}, d[i].carry} << 64);
      total = total + (term << (64 * i));
    end
    pw  = {44'd0, Mod};
    neg = total[299];
    mag = neg ? (300'd0 - total) : total;
    q   = neg ? ((mag + pw - 300'd1) / pw) : (mag / pw);
    if (q > 300'd8) begin
      k = MAX_RED;
      e = 1'b1;
    end else begin
      k = int'(q[7:0]);
      e = 1'b0;
    end
    res = neg ? (total + pw * 300'(k)) : (total - pw * 300'(k));
    return {e, 8'(ADD_DIV + k + 2), res[W_FP-1:0]};
  endfunction

  function automatic redundant_poly_L3 from_int(input uint_fp_t t,
                                                input logic [W_CARRY-1:0] c3);
    redundant_poly_L3 w;
    w = '0;
    for (int i = 0; i < ADD_DIV; i++) w[i].val = t[64*i +: 64];
    w[ADD_DIV-1].carry = c3;
    return w;
  endfunction

  function automatic redundant_poly_L3 rand_word();
    redundant_poly_L3 w;
    uint_fp_t         t, m;
    int               kind;
    kind = $urandom_range(0, 5);
    m = Mod;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w = '0;
    case (kind)
      0: begin
        for (int i = 0; i < ADD_DIV; i++) begin
          w[i].val   = {$urandom, $urandom};
          w[i].carry = W_CARRY'($urandom_range(0, 6) - 3);
        end
        w[ADD_DIV-1].val   = w[ADD_DIV-1].val & 64'h3fff_ffff_ffff_ffff;
        w[ADD_DIV-1].carry = '0;
      end
      1: begin
        for (int i = 0; i < ADD_DIV; i++) begin
          w[i].val   = {$urandom, $urandom};
          w[i].carry = W_CARRY'($urandom);
        end
      end
      2: w = from_int(uint_fp_t'($urandom_range(0, 5)) * m + (t >> 200), '0);
      3: w = from_int(uint_fp_t'(0) - uint_fp_t'($urandom_range(1, 5)) * m + (t >> 200), 8'hff);
      4: w = from_int(t, 8'h01);
      default: begin
        w = from_int(m, '0);
        w[0].val   = w[0].val + 64'($urandom_range(0, 3)) - 64'd2;
        w[0].carry = W_CARRY'($urandom_range(0, 2) - 1);
      end
    endcase
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input redundant_poly_L3 d, input int junk);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
      return;
    end
    din      = d;
    in_valid = 1'b1;
    exp_q.push_back(model(d));
    acc_q.push_back(cycle + 1);
    @(negedge clk);
    // Offers while busy must be ignored, not queued.
    for (int j = 0; j < junk; j++) begin
      din = rand_word();
      check("busy_in_ready", W_FP'(in_ready), W_FP'(0));
      @(negedge clk);
    end
    in_valid = 1'b0;
    din      = '0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (out_valid) hold_cnt++;
    else hold_cnt = 0;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (hold_cnt > 5);
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  logic             ov_prev = 1'b0;
  logic             hs_prev = 1'b0;
  logic [EXP_W-1:0] mon_e;
  int               mon_a;
  uint_fp_t         held_dout;
  logic             held_err;

  always @(negedge clk) begin
    if (!rstn) begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("valid_drop_after_hs", W_FP'(out_valid), W_FP'(0));
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: dout %h err %0b", dout, err);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          check("dout", dout, mon_e[W_FP-1:0]);
          check("err", W_FP'(err), W_FP'(mon_e[EXP_W-1]));
          check("latency", W_FP'(cycle - mon_a), W_FP'(mon_e[EXP_W-2:W_FP]));
        end
        held_dout = dout;
        held_err  = err;
      end else if (out_valid && ov_prev) begin
        check("hold_dout", dout, held_dout);
        check("hold_err", W_FP'(err), W_FP'(held_err));
        check("hold_in_ready", W_FP'(in_ready), W_FP'(0));
      end
      hs_prev = out_valid && out_ready;
      ov_prev = out_valid && !out_ready;
    end
  end

  // ---------------- stimulus ----------------
  redundant_poly_L3 w;
  uint_fp_t         mval;

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", W_FP'(out_valid), W_FP'(0));
    check("rst_in_ready", W_FP'(in_ready), W_FP'(0));
    check("rst_dout", dout, W_FP'(0));
    check("rst_err", W_FP'(err), W_FP'(0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", W_FP'(in_ready), W_FP'(1));

    bp_mode = 0;
    w = '0;
    send(w, 3);
    drain();

    mval = Mod;
    w = from_int(mval, '0);
    send(w, 0);
    drain();

    w = '0;
    w[0].carry = 8'hff;
    send(w, 2);
    drain();

    // Carry of limb 0 cancels against limb 1: total is 2^64-1.
    w = '0;
    w[0].val   = '1;
    w[0].carry = 8'h01;
    w[1].val   = '1;
    w[1].carry = 8'hff;
    send(w, 0);
    drain();

    w = '0;
    w[3].carry = 8'h7f;
    send(w, 1);
    drain();

    // Back-pressure: out_ready low for 5 cycles, next word offered at once.
    bp_mode = 2;
    send(rand_word(), 0);
    send(rand_word(), 0);
    drain();
    bp_mode = 0;

    // Reset in the middle of RESOLVE aborts the word.
    send(rand_word(), 0);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_out_valid", W_FP'(out_valid), W_FP'(0));
    check("async_rst_in_ready", W_FP'(in_ready), W_FP'(0));
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("async_rst_dout", dout, W_FP'(0));
    @(negedge clk);
    rstn = 1'b1;
    mval = Mod;
    send(from_int(mval - 256'd5, '0), 0);
    drain();

    for (int n = 0; n < 150; n++) begin
      bp_mode = (n >= 75) ? 1 : 0;
      send(rand_word(), $urandom_range(0, 3));
      drain();
    end

    bp_mode = 0;
    repeat (10) @(negedge clk);
    check("final_idle", W_FP'(out_valid), W_FP'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
